// File: rtl/rs_mul_sched_pkg.sv
// Shared constants, entry record and operand-snoop helpers for the multiply reservation station.
package rs_mul_sched_pkg;

  localparam int RS_ENTRIES     = 4;
  localparam int RS_DATA_LEN    = 32;
  localparam int RS_RRF_TAG_LEN = 6;
  localparam int RS_SPECTAG_LEN = 5;

  typedef struct packed {
    logic                      valid;
    logic                      src1_rdy;
    logic [RS_DATA_LEN-1:0]    src1;
    logic [RS_RRF_TAG_LEN-1:0] src1_tag;
    logic                      src2_rdy;
    logic [RS_DATA_LEN-1:0]    src2;
    logic [RS_RRF_TAG_LEN-1:0] src2_tag;
    logic [RS_RRF_TAG_LEN-1:0] rrftag;
    logic                      dstval;
    logic [RS_SPECTAG_LEN-1:0] spectag;
    logic                      specbit;
    logic                      src1_signed;
    logic                      src2_signed;
    logic                      sel_lohi;
  } rs_entry_t;

  // Returns {rdy, data}; bc0 wins when both buses carry the awaited tag.
  function automatic logic [RS_DATA_LEN:0] snoop_src(
    input logic                      rdy,
    input logic [RS_DATA_LEN-1:0]    data,
    input logic [RS_RRF_TAG_LEN-1:0] tag,
    input logic                      b0_v,
    input logic [RS_RRF_TAG_LEN-1:0] b0_t,
    input logic [RS_DATA_LEN-1:0]    b0_d,
    input logic                      b1_v,
    input logic [RS_RRF_TAG_LEN-1:0] b1_t,
    input logic [RS_DATA_LEN-1:0]    b1_d
  );
    logic [RS_DATA_LEN:0] res;
    if (rdy) begin
      res = {1'b1, data};
    end else if (b0_v && (b0_t == tag)) begin
      res = {1'b1, b0_d};
    end else if (b1_v && (b1_t == tag)) begin
      res = {1'b1, b1_d};
    end else begin
      res = {1'b0, data};
    end
    return res;
  endfunction

  function automatic logic spec_hit(
    input logic                      specbit,
    input logic [RS_SPECTAG_LEN-1:0] spectag,
    input logic [RS_SPECTAG_LEN-1:0] fix
  );
    return specbit && (|(spectag & fix));
  endfunction

endpackage

// File: rtl/rs_mul_oldest_sel.sv
// Combinational oldest-ready picker: older[j*ENTRIES+i] set means entry j is older than entry i.
module rs_mul_oldest_sel
  import rs_mul_sched_pkg::*;
#(
  parameter int ENTRIES = RS_ENTRIES
) (
  input  logic [ENTRIES-1:0]         req,
  input  logic [ENTRIES*ENTRIES-1:0] older,
  output logic [ENTRIES-1:0]         grant
);

  logic [ENTRIES-1:0] blocked_s;

  // A requester is blocked by any other requester that is older than it.
  always_comb begin
    blocked_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      for (int j = 0; j < ENTRIES; j++) begin
        blocked_s[i] = blocked_s[i] | ((j != i) && req[j] && older[j*ENTRIES+i]);
      end
    end
    grant = req & ~blocked_s;
  end

endmodule

// File: rtl/rs_mul_sched.sv
// Multiply-pipe reservation station: buffers ops, wakes operands from two broadcast buses,
// issues the oldest ready op when the multiplier is idle, and squashes on mispredict.
module rs_mul_sched
  import rs_mul_sched_pkg::*;
#(
  parameter int ENTRIES     = RS_ENTRIES,
  parameter int DATA_LEN    = RS_DATA_LEN,
  parameter int RRF_TAG_LEN = RS_RRF_TAG_LEN,
  parameter int SPECTAG_LEN = RS_SPECTAG_LEN
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [DATA_LEN-1:0]    disp_src1,
  input  logic [DATA_LEN-1:0]    disp_src2,
  input  logic                   disp_src1_rdy,
  input  logic                   disp_src2_rdy,
  input  logic [RRF_TAG_LEN-1:0] disp_src1_tag,
  input  logic [RRF_TAG_LEN-1:0] disp_src2_tag,
  input  logic [RRF_TAG_LEN-1:0] disp_rrftag,
  input  logic                   disp_dstval,
  input  logic [SPECTAG_LEN-1:0] disp_spectag,
  input  logic                   disp_specbit,
  input  logic                   disp_src1_signed,
  input  logic                   disp_src2_signed,
  input  logic                   disp_sel_lohi,
  input  logic                   bc0_valid,
  input  logic                   bc1_valid,
  input  logic [RRF_TAG_LEN-1:0] bc0_tag,
  input  logic [RRF_TAG_LEN-1:0] bc1_tag,
  input  logic [DATA_LEN-1:0]    bc0_data,
  input  logic [DATA_LEN-1:0]    bc1_data,
  input  logic                   ex_busy,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] spectagfix,
  output logic                   issue,
  output logic [DATA_LEN-1:0]    ex_src1,
  output logic [DATA_LEN-1:0]    ex_src2,
  output logic [RRF_TAG_LEN-1:0] ex_rrftag,
  output logic                   ex_dstval,
  output logic [SPECTAG_LEN-1:0] ex_spectag,
  output logic                   ex_specbit,
  output logic                   ex_src1_signed,
  output logic                   ex_src2_signed,
  output logic                   ex_sel_lohi,
  output logic [$clog2(ENTRIES):0] count
);

  localparam int IDX_LEN = $clog2(ENTRIES);

  rs_entry_t                  ent_r     [ENTRIES];
  rs_entry_t                  ent_nxt_s [ENTRIES];
  logic [ENTRIES-1:0]         age_r     [ENTRIES];
  logic [ENTRIES*ENTRIES-1:0] age_flat_s;
  logic [ENTRIES-1:0]         req_s, grant_s, kill_s;
  rs_entry_t                  sel_ent_s, disp_ent_s;
  logic [IDX_LEN-1:0]         disp_idx_s;
  logic                       disp_keep_s;
  logic [IDX_LEN:0]           cnt_nxt_s, count_r;
  logic                       disp_ready_r, issue_r;
  rs_entry_t                  ex_r;

  // Kill detection and request vector; issue_r blocks the cycle before ex_busy can rise.
  always_comb begin
    req_s  = '0;
    kill_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      age_flat_s[i*ENTRIES +: ENTRIES] = age_r[i];
      kill_s[i] = prmiss && ent_r[i].valid && spec_hit(ent_r[i].specbit, ent_r[i].spectag, spectagfix);
      req_s[i]  = ent_r[i].valid && ent_r[i].src1_rdy && ent_r[i].src2_rdy && !kill_s[i]
                  && !ex_busy && !issue_r;
    end
  end

  rs_mul_oldest_sel #(.ENTRIES(ENTRIES)) u_sel (
    .req   (req_s),
    .older (age_flat_s),
    .grant (grant_s)
  );

  // Next entry state: wakeup, branch resolution, free on issue/kill, lowest-free dispatch.
  always_comb begin
    sel_ent_s  = '0;
    disp_idx_s = '0;
    for (int i = ENTRIES-1; i >= 0; i--) begin
      disp_idx_s = ent_r[i].valid ? disp_idx_s : IDX_LEN'(i);
    end
    disp_keep_s = disp_valid && disp_ready_r && !(prmiss && spec_hit(disp_specbit, disp_spectag, spectagfix));

    disp_ent_s             = '0;
    disp_ent_s.valid       = 1'b1;
    {disp_ent_s.src1_rdy, disp_ent_s.src1} = snoop_src(disp_src1_rdy, disp_src1, disp_src1_tag,
        bc0_valid, bc0_tag, bc0_data, bc1_valid, bc1_tag, bc1_data);
    {disp_ent_s.src2_rdy, disp_ent_s.src2} = snoop_src(disp_src2_rdy, disp_src2, disp_src2_tag,
        bc0_valid, bc0_tag, bc0_data, bc1_valid, bc1_tag, bc1_data);
    disp_ent_s.src1_tag    = disp_src1_tag;
    disp_ent_s.src2_tag    = disp_src2_tag;
    disp_ent_s.rrftag      = disp_rrftag;
    disp_ent_s.dstval      = disp_dstval;
    disp_ent_s.spectag     = disp_spectag;
    disp_ent_s.specbit     = disp_specbit && !(prsuccess && spec_hit(disp_specbit, disp_spectag, spectagfix));
    disp_ent_s.src1_signed = disp_src1_signed;
    disp_ent_s.src2_signed = disp_src2_signed;
    disp_ent_s.sel_lohi    = disp_sel_lohi;

    cnt_nxt_s = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      sel_ent_s    = rs_entry_t'(sel_ent_s | (ent_r[i] & {$bits(rs_entry_t){grant_s[i]}}));
      ent_nxt_s[i] = ent_r[i];
      {ent_nxt_s[i].src1_rdy, ent_nxt_s[i].src1} = snoop_src(ent_r[i].src1_rdy, ent_r[i].src1,
          ent_r[i].src1_tag, bc0_valid, bc0_tag, bc0_data, bc1_valid, bc1_tag, bc1_data);
      {ent_nxt_s[i].src2_rdy, ent_nxt_s[i].src2} = snoop_src(ent_r[i].src2_rdy, ent_r[i].src2,
          ent_r[i].src2_tag, bc0_valid, bc0_tag, bc0_data, bc1_valid, bc1_tag, bc1_data);
      ent_nxt_s[i].specbit = ent_r[i].specbit
                             && !(prsuccess && spec_hit(ent_r[i].specbit, ent_r[i].spectag, spectagfix));
      ent_nxt_s[i].valid   = ent_r[i].valid && !kill_s[i] && !grant_s[i];
      ent_nxt_s[i] = (disp_keep_s && (disp_idx_s == IDX_LEN'(i))) ? disp_ent_s : ent_nxt_s[i];
      cnt_nxt_s    = cnt_nxt_s + (IDX_LEN+1)'(ent_nxt_s[i].valid);
    end
  end

  // Entry storage, occupancy and dispatch credit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_r[i] <= '0;
      end
      count_r      <= '0;
      disp_ready_r <= 1'b1;
    end else begin
      ent_r        <= ent_nxt_s;
      count_r      <= cnt_nxt_s;
      disp_ready_r <= (cnt_nxt_s < (IDX_LEN+1)'(ENTRIES));
    end
  end

  // Age matrix: a new entry is younger than every other slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        age_r[i] <= '0;
      end
    end else if (disp_keep_s) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_LEN'(i) == disp_idx_s) begin
          age_r[i] <= '0;
        end else begin
          age_r[i][disp_idx_s] <= 1'b1;
        end
      end
    end
  end

  // Issue pulse and operand hold registers for the multiplier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_r <= 1'b0;
      ex_r    <= '0;
    end else begin
      issue_r <= |grant_s;
      if (|grant_s) begin
        ex_r         <= sel_ent_s;
        ex_r.specbit <= sel_ent_s.specbit
                        && !(prsuccess && spec_hit(sel_ent_s.specbit, sel_ent_s.spectag, spectagfix));
      end else if (prsuccess && spec_hit(ex_r.specbit, ex_r.spectag, spectagfix)) begin
        ex_r.specbit <= 1'b0;
      end
    end
  end

  assign disp_ready     = disp_ready_r;
  assign count          = count_r;
  assign issue          = issue_r;
  assign ex_src1        = ex_r.src1;
  assign ex_src2        = ex_r.src2;
  assign ex_rrftag      = ex_r.rrftag;
  assign ex_dstval      = ex_r.dstval;
  assign ex_spectag     = ex_r.spectag;
  assign ex_specbit     = ex_r.specbit;
  assign ex_src1_signed = ex_r.src1_signed;
  assign ex_src2_signed = ex_r.src2_signed;
  assign ex_sel_lohi    = ex_r.sel_lohi;

endmodule

// File: tb/tb_rs_mul_sched.sv
// Directed bench for rs_mul_sched with an in-order queue model of the station.
module tb_rs_mul_sched;

  localparam int E = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        disp_valid, disp_ready;
  logic [31:0] disp_src1, disp_src2;
  logic        disp_src1_rdy, disp_src2_rdy;
  logic [5:0]  disp_src1_tag, disp_src2_tag, disp_rrftag;
  logic        disp_dstval;
  logic [4:0]  disp_spectag;
  logic        disp_specbit, disp_src1_signed, disp_src2_signed, disp_sel_lohi;
  logic        bc0_valid, bc1_valid;
  logic [5:0]  bc0_tag, bc1_tag;
  logic [31:0] bc0_data, bc1_data;
  logic        ex_busy, prmiss, prsuccess;
  logic [4:0]  spectagfix;
  logic        issue;
  logic [31:0] ex_src1, ex_src2;
  logic [5:0]  ex_rrftag;
  logic        ex_dstval;
  logic [4:0]  ex_spectag;
  logic        ex_specbit, ex_src1_signed, ex_src2_signed, ex_sel_lohi;
  logic [2:0]  count;

  always #5 clk = ~clk;

  rs_mul_sched dut (
    .clk(clk), .reset_n(reset_n), .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_src1(disp_src1), .disp_src2(disp_src2), .disp_src1_rdy(disp_src1_rdy),
    .disp_src2_rdy(disp_src2_rdy), .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
    .disp_rrftag(disp_rrftag), .disp_dstval(disp_dstval), .disp_spectag(disp_spectag),
    .disp_specbit(disp_specbit), .disp_src1_signed(disp_src1_signed),
    .disp_src2_signed(disp_src2_signed), .disp_sel_lohi(disp_sel_lohi),
    .bc0_valid(bc0_valid), .bc1_valid(bc1_valid), .bc0_tag(bc0_tag), .bc1_tag(bc1_tag),
    .bc0_data(bc0_data), .bc1_data(bc1_data), .ex_busy(ex_busy), .prmiss(prmiss),
    .prsuccess(prsuccess), .spectagfix(spectagfix), .issue(issue), .ex_src1(ex_src1),
    .ex_src2(ex_src2), .ex_rrftag(ex_rrftag), .ex_dstval(ex_dstval), .ex_spectag(ex_spectag),
    .ex_specbit(ex_specbit), .ex_src1_signed(ex_src1_signed), .ex_src2_signed(ex_src2_signed),
    .ex_sel_lohi(ex_sel_lohi), .count(count)
  );

  typedef struct {
    bit          r1;
    logic [31:0] d1;
    logic [5:0]  t1;
    bit          r2;
    logic [31:0] d2;
    logic [5:0]  t2;
    logic [5:0]  rrf;
    logic [4:0]  stag;
    bit          sbit;
  } op_t;

  // Model: queue in dispatch order, so the oldest ready op is the first ready one.
  op_t         q[$];
  bit          m_issue;
  int          m_count;
  logic [31:0] m_s1, m_s2;
  logic [5:0]  m_rrf;
  logic [4:0]  m_stag;
  bit          m_sbit;
  int          total, bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void snoop(input bit r, input logic [31:0] d, input logic [5:0] t,
                                output bit ro, output logic [31:0] dout);
    ro = r;
    dout = d;
    if (!r && bc0_valid && bc0_tag == t) begin
      ro = 1'b1; dout = bc0_data;
    end else if (!r && bc1_valid && bc1_tag == t) begin
      ro = 1'b1; dout = bc1_data;
    end
  endfunction

  function automatic bit tag_hit(input bit sb, input logic [4:0] st);
    return sb && ((st & spectagfix) != 5'd0);
  endfunction

  task automatic model_step();
    op_t nq[$];
    op_t o;
    int  sel = -1;
    if (!ex_busy && !m_issue) begin
      for (int k = 0; k < q.size(); k++) begin
        if (sel < 0 && q[k].r1 && q[k].r2 && !(prmiss && tag_hit(q[k].sbit, q[k].stag))) sel = k;
      end
    end
    if (sel >= 0) begin
      m_s1 = q[sel].d1; m_s2 = q[sel].d2; m_rrf = q[sel].rrf; m_stag = q[sel].stag;
      m_sbit = q[sel].sbit && !(prsuccess && tag_hit(q[sel].sbit, q[sel].stag));
    end else if (prsuccess && tag_hit(m_sbit, m_stag)) begin
      m_sbit = 1'b0;
    end
    for (int k = 0; k < q.size(); k++) begin
      if (k != sel && !(prmiss && tag_hit(q[k].sbit, q[k].stag))) begin
        o = q[k];
        snoop(o.r1, o.d1, o.t1, o.r1, o.d1);
        snoop(o.r2, o.d2, o.t2, o.r2, o.d2);
        if (prsuccess && tag_hit(o.sbit, o.stag)) o.sbit = 1'b0;
        nq.push_back(o);
      end
    end
    if (disp_valid && m_count < E && !(prmiss && tag_hit(disp_specbit, disp_spectag))) begin
      o.rrf = disp_rrftag; o.stag = disp_spectag; o.t1 = disp_src1_tag; o.t2 = disp_src2_tag;
      snoop(disp_src1_rdy, disp_src1, disp_src1_tag, o.r1, o.d1);
      snoop(disp_src2_rdy, disp_src2, disp_src2_tag, o.r2, o.d2);
      o.sbit = disp_specbit && !(prsuccess && tag_hit(disp_specbit, disp_spectag));
      nq.push_back(o);
    end
    q = nq;
    m_issue = (sel >= 0);
    m_count = q.size();
  endtask

  task automatic compare_all();
    check("issue", issue, m_issue);
    check("count", count, m_count);
    check("disp_ready", disp_ready, m_count < E);
    check("ex_src1", ex_src1, m_s1);
    check("ex_src2", ex_src2, m_s2);
    check("ex_rrftag", ex_rrftag, m_rrf);
    check("ex_spectag", ex_spectag, m_stag);
    check("ex_specbit", ex_specbit, m_sbit);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    disp_valid = 1'b0; bc0_valid = 1'b0; bc1_valid = 1'b0;
    prmiss = 1'b0; prsuccess = 1'b0;
  endtask

  task automatic disp(input logic [31:0] s1, input bit r1, input logic [5:0] t1,
                      input logic [31:0] s2, input bit r2, input logic [5:0] t2,
                      input logic [5:0] rrf, input logic [4:0] stag, input bit sbit);
    disp_valid = 1'b1;
    disp_src1 = s1; disp_src1_rdy = r1; disp_src1_tag = t1;
    disp_src2 = s2; disp_src2_rdy = r2; disp_src2_tag = t2;
    disp_rrftag = rrf; disp_spectag = stag; disp_specbit = sbit;
  endtask

  initial begin
    total = 0; bad = 0;
    m_issue = 0; m_count = 0; m_s1 = '0; m_s2 = '0; m_rrf = '0; m_stag = '0; m_sbit = 0;
    reset_n = 1'b0; idle(); ex_busy = 1'b0; spectagfix = 5'd0;
    disp(32'd0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 6'd0, 5'd0, 1'b0);
    disp_valid = 1'b0; disp_dstval = 1'b1;
    disp_src1_signed = 1'b0; disp_src2_signed = 1'b0; disp_sel_lohi = 1'b0;
    bc0_tag = '0; bc1_tag = '0; bc0_data = '0; bc1_data = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    check("rst_issue", issue, 1'b0);
    check("rst_count", count, 3'd0);
    check("rst_ready", disp_ready, 1'b1);
    check("rst_ex_src1", ex_src1, 32'd0);
    compare_all();

    // 3 x 5, both ready: issue two edges after dispatch
    disp(32'd3, 1'b1, 6'd0, 32'd5, 1'b1, 6'd0, 6'd1, 5'd0, 1'b0);
    tick(); idle();
    check("t1_pre_issue", issue, 1'b0);
    tick();
    check("t1_issue", issue, 1'b1);
    check("t1_src1", ex_src1, 32'd3);
    check("t1_src2", ex_src2, 32'd5);
    check("t1_count", count, 3'd0);
    tick();
    check("t1_pulse", issue, 1'b0);

    // A then B waiting on tag 7; bc1 wakes B
    disp(32'd4, 1'b1, 6'd0, 32'd6, 1'b1, 6'd0, 6'd2, 5'd0, 1'b0);
    tick();
    disp(32'd8, 1'b1, 6'd0, 32'd0, 1'b0, 6'd7, 6'd3, 5'd0, 1'b0);
    tick(); idle();
    check("t2_a_issue", ex_src1, 32'd4);
    tick();
    bc1_valid = 1'b1; bc1_tag = 6'd7; bc1_data = 32'd9;
    tick(); idle();
    check("t2_no_early", issue, 1'b0);
    tick();
    check("t2_b_issue", issue, 1'b1);
    check("t2_b_src2", ex_src2, 32'd9);
    check("t2_b_rrf", ex_rrftag, 6'd3);
    repeat (2) tick();

    // Dispatch snoops both buses in the same cycle; bc0 wins
    disp(32'd0, 1'b0, 6'd12, 32'd2, 1'b1, 6'd0, 6'd4, 5'd0, 1'b0);
    bc0_valid = 1'b1; bc0_tag = 6'd12; bc0_data = 32'd21;
    bc1_valid = 1'b1; bc1_tag = 6'd12; bc1_data = 32'd99;
    tick(); idle();
    tick();
    check("snoop_bc0", ex_src1, 32'd21);
    repeat (2) tick();

    // Fill while busy, fifth dispatch ignored, oldest first, reuse of a freed slot
    ex_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      disp(32'd10 + 32'(k), 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd10 + 6'(k), 5'd0, 1'b0);
      tick();
    end
    check("full_ready", disp_ready, 1'b0);
    check("full_count", count, 3'd4);
    disp(32'd99, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd20, 5'd0, 1'b0);
    tick(); idle();
    check("full_ignored", count, 3'd4);
    ex_busy = 1'b0;
    tick();
    check("oldest_first", ex_src1, 32'd10);
    ex_busy = 1'b1;
    disp(32'd50, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd21, 5'd0, 1'b0);
    tick(); idle();
    tick();
    ex_busy = 1'b0;
    tick();
    check("age_after_reuse", ex_src1, 32'd11);
    repeat (10) tick();

    // Mispredict kills two queued spec ops and drops a matching dispatch
    ex_busy = 1'b1;
    disp(32'd30, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd30, 5'b00010, 1'b1);
    tick();
    disp(32'd31, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd31, 5'b00000, 1'b0);
    tick();
    disp(32'd32, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd32, 5'b00010, 1'b1);
    tick(); idle();
    check("kill_pre", count, 3'd3);
    disp(32'd33, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd33, 5'b00010, 1'b1);
    prmiss = 1'b1; spectagfix = 5'b00010;
    tick(); idle();
    check("kill_count", count, 3'd1);
    check("kill_no_issue", issue, 1'b0);
    ex_busy = 1'b0;
    tick();
    check("kill_survivor", ex_src1, 32'd31);
    repeat (3) tick();

    // Operands held through a busy window; prsuccess clears ex_specbit
    disp(32'd70, 1'b1, 6'd0, 32'd71, 1'b1, 6'd0, 6'd40, 5'b00100, 1'b1);
    tick(); idle();
    tick();
    check("hold_issue", issue, 1'b1);
    check("hold_specbit", ex_specbit, 1'b1);
    disp(32'd80, 1'b1, 6'd0, 32'd81, 1'b1, 6'd0, 6'd41, 5'd0, 1'b0);
    tick(); idle();
    ex_busy = 1'b1; prsuccess = 1'b1; spectagfix = 5'b00100;
    tick(); prsuccess = 1'b0;
    check("prsuccess_ex", ex_specbit, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_src1", ex_src1, 32'd70);
      check("hold_no_issue", issue, 1'b0);
    end
    ex_busy = 1'b0;
    tick();
    check("after_busy", ex_src1, 32'd80);
    repeat (2) tick();

    // Asynchronous reset with three entries valid
    ex_busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      disp(32'd60 + 32'(k), 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 6'd50, 5'd0, 1'b0);
      tick();
    end
    idle();
    check("pre_rst_count", count, 3'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_count", count, 3'd0);
    check("arst_issue", issue, 1'b0);
    check("arst_ready", disp_ready, 1'b1);
    q.delete();
    m_issue = 0; m_count = 0; m_s1 = '0; m_s2 = '0; m_rrf = '0; m_stag = '0; m_sbit = 0;
    @(negedge clk);
    reset_n = 1'b1; ex_busy = 1'b0;
    tick();
    disp(32'd1, 1'b1, 6'd0, 32'd2, 1'b1, 6'd0, 6'd5, 5'd0, 1'b0);
    tick(); idle();
    tick();
    check("post_rst_issue", ex_src1, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
